// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: Wishbone-to-OpenRAM 1RW1R controller with burst reader.
// Optional burst reader on port 1 is enabled by `define SRAM_CTRL_RDBURST_EN.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock (also SRAM clk0/clk1), async active-high reset
//   wbs_*                 Wishbone classic slave port
//   csb0_o .. dout0_i     SRAM port 0 (RW), all outputs registered
//   csb1_o, addr1_o,
//   dout1_i               SRAM port 1 (R), outputs registered
//   rd_start_i, rd_addr_i,
//   rd_len_i              burst request (one-cycle start pulse)
//   rd_data_o, rd_valid_o,
//   rd_ready_i, rd_busy_o burst stream out (valid/ready) and busy flag

module sram_1rw1r_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  csb0_o,
    output logic                  web0_o,
    output logic [NUM_WMASKS-1:0] wmask0_o,
    output logic [ADDR_WIDTH-1:0] addr0_o,
    output logic [DATA_WIDTH-1:0] din0_o,
    input  logic [DATA_WIDTH-1:0] dout0_i,
    output logic                  csb1_o,
    output logic [ADDR_WIDTH-1:0] addr1_o,
    input  logic [DATA_WIDTH-1:0] dout1_i,
    input  logic                  rd_start_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ADDR_WIDTH:0]   rd_len_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  rd_busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t state;
    logic   req;
    logic   wr_issue;

    assign req = wbs_cyc_i & wbs_stb_i;

    // Port 0 registers a write on this edge; port 1 must stay quiet.
    assign wr_issue = (state == IDLE) & req & wbs_we_i;

    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Port 0: Wishbone transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            csb0_o    <= 1'b1;
            web0_o    <= 1'b1;
            wmask0_o  <= '0;
            addr0_o   <= '0;
            din0_o    <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        csb0_o   <= 1'b0;
                        web0_o   <= ~wbs_we_i;
                        addr0_o  <= wbs_adr_i[ADDR_WIDTH+1:2];
                        din0_o   <= wbs_dat_i;
                        wmask0_o <= wbs_we_i ? wbs_sel_i : '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    csb0_o <= 1'b1;
                    if (!web0_o) begin
                        // Ack only if the master is still in the cycle.
                        wbs_ack_o <= wbs_cyc_i;
                        state     <= ACK;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // dout0 is valid from the previous negedge until now.
                    wbs_dat_o <= dout0_i;
                    wbs_ack_o <= wbs_cyc_i;
                    state     <= ACK;
                end
                ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_CTRL_RDBURST_EN
    // ------------------------------------------------------------------
    // Port 1: burst reader with 4-entry return FIFO
    // ------------------------------------------------------------------
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [ADDR_WIDTH:0]   ONE_R = 1;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  busy;
    logic                  s1;
    logic                  s2;
    logic [DATA_WIDTH-1:0] fifo [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count;
    logic [2:0]            pending;
    logic                  issue;
    logic                  pop;
    logic                  last;

    // s1: read sampled by macro at the coming edge.
    // s2: read data valid, captured at the coming edge.
    assign s1      = ~csb1_o;
    assign pending = count + {2'b00, s1} + {2'b00, s2};

    // Reserve FIFO space for every read in flight so nothing is dropped.
    assign issue = busy && (remaining != '0)
                   && (pending < 3'd4) && !wr_issue;

    assign pop  = (count != 3'd0) && rd_ready_i;
    assign last = pop && (count == 3'd1) && (remaining == '0)
                  && !s1 && !s2;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csb1_o    <= 1'b1;
            addr1_o   <= '0;
            next_addr <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            s2        <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
        end else begin
            if (issue) begin
                csb1_o    <= 1'b0;
                addr1_o   <= next_addr;
                next_addr <= next_addr + ONE_A;
                remaining <= remaining - ONE_R;
            end else begin
                csb1_o <= 1'b1;
            end

            s2 <= s1;

            if (s2) begin
                fifo[wr_ptr] <= dout1_i;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;

            unique case ({s2, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (!busy) begin
                if (rd_start_i && (rd_len_i != '0)) begin
                    busy      <= 1'b1;
                    next_addr <= rd_addr_i;
                    remaining <= rd_len_i;
                end
            end else if (last) begin
                busy <= 1'b0;
            end
        end
    end

    assign rd_data_o  = fifo[rd_ptr];
    assign rd_valid_o = (count != 3'd0);
    assign rd_busy_o  = busy;
`else
    assign csb1_o     = 1'b1;
    assign addr1_o    = '0;
    assign rd_data_o  = '0;
    assign rd_valid_o = 1'b0;
    assign rd_busy_o  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{rd_start_i, rd_addr_i, rd_len_i,
                         dout1_i, rd_ready_i, wr_issue};
`endif

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: directed bench for sram_1rw1r_ctrl with a behavioural
// 1RW1R SRAM model; burst checks apply when SRAM_CTRL_RDBURST_EN is defined.

module tb_sram_1rw1r_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic        rd_start;
    logic [7:0]  rd_addr;
    logic [8:0]  rd_len;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready, rd_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_1rw1r_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .csb0_o     (csb0),
        .web0_o     (web0),
        .wmask0_o   (wmask0),
        .addr0_o    (addr0),
        .din0_o     (din0),
        .dout0_i    (dout0),
        .csb1_o     (csb1),
        .addr1_o    (addr1),
        .dout1_i    (dout1),
        .rd_start_i (rd_start),
        .rd_addr_i  (rd_addr),
        .rd_len_i   (rd_len),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_busy_o  (rd_busy)
    );

    // SRAM model: inputs registered on posedge, data valid from the
    // following negedge until the next posedge, garbage afterwards.
    logic [31:0] mem [256];
    logic        init_done = 1'b0;
    logic        m0_rd = 1'b0, m1_rd = 1'b0;
    logic [7:0]  m0_a = '0, m1_a = '0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
            init_done <= 1'b1;
        end else if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
        m0_rd <= !csb0 && web0;
        m0_a  <= addr0;
        m1_rd <= !csb1;
        m1_a  <= addr1;
        dout0 <= 32'hBAD0_0000;
        dout1 <= 32'hBAD1_0000;
    end

    always @(negedge clk) begin
        if (m0_rd) dout0 <= mem[m0_a];
        if (m1_rd) dout1 <= mem[m1_a];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream monitor, sampled on negedge
    logic        mon_en = 1'b0;
    int          cyc_n = 0;
    int          coll_n = 0;
    logic [7:0]  iss_q [$];
    logic [31:0] got_q [$];
    int          got_cyc [$];
    logic        busy_q [$];

    always @(negedge clk) begin
        cyc_n++;
        if (mon_en) begin
            if (!csb1) iss_q.push_back(addr1);
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                got_cyc.push_back(cyc_n);
                busy_q.push_back(rd_busy);
            end
            if (!csb0 && !web0) begin
                coll_n++;
                chk("coll_csb1", {31'b0, csb1}, 32'd1);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [7:0]  exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [10];

    task automatic wb_xfer(input vec_t v);
        cyc = 1'b1; stb = 1'b1; we = v.we;
        adr = v.adr; dat_i = v.dat; sel = v.sel;
        @(posedge clk); #1;
        chk("csb0_low", {31'b0, csb0}, 32'd0);
        chk("web0", {31'b0, web0}, {31'b0, !v.we});
        chk("addr0", {24'b0, addr0}, {24'b0, v.exp_addr});
        chk("wmask0", {28'b0, wmask0}, {28'b0, v.exp_mask});
        if (v.we) chk("din0", din0, v.dat);
        @(posedge clk); #1;
        chk("csb0_one_cycle", {31'b0, csb0}, 32'd1);
        if (v.we) begin
            chk("wr_ack", {31'b0, ack}, 32'd1);
        end else begin
            chk("rd_ack_early", {31'b0, ack}, 32'd0);
            @(posedge clk); #1;
            chk("rd_ack", {31'b0, ack}, 32'd1);
            chk("rd_data", dat_o, v.exp_dat);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'b0, ack}, 32'd0);
    endtask

    task automatic burst_start(input logic [7:0] a, input logic [8:0] n);
        rd_addr = a; rd_len = n; rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic clear_mon();
        iss_q.delete(); got_q.delete(); got_cyc.delete(); busy_q.delete();
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("burst_words", got_q.size(), n);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 8'h04, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h010, 32'h0, 4'hF, 8'h04, 4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h014, 32'hDEADBEEF, 4'hF, 8'h05, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 32'h014, 32'h11223344, 4'h3, 8'h05, 4'h3, 32'h0};
        vecs[4] = '{1'b0, 32'h014, 32'h0, 4'hF, 8'h05, 4'h0, 32'hDEAD3344};
        vecs[5] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hC, 8'hFF, 4'hC, 32'h0};
        vecs[6] = '{1'b0, 32'h3FC, 32'h0, 4'hF, 8'hFF, 4'h0, 32'hA5A500FF};
        vecs[7] = '{1'b1, 32'h400, 32'h000000CC, 4'h1, 8'h00, 4'h1, 32'h0};
        vecs[8] = '{1'b0, 32'h000, 32'h0, 4'hF, 8'h00, 4'h0, 32'h5A0000CC};
        vecs[9] = '{1'b0, 32'h020, 32'h0, 4'hF, 8'h08, 4'h0, 32'h5A000008};

        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        rd_start = 0; rd_addr = 0; rd_len = 0; rd_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb0", {31'b0, csb0}, 32'd1);
        chk("rst_web0", {31'b0, web0}, 32'd1);
        chk("rst_csb1", {31'b0, csb1}, 32'd1);
        chk("rst_wmask0", {28'b0, wmask0}, 32'd0);
        chk("rst_addr0", {24'b0, addr0}, 32'd0);
        chk("rst_din0", din0, 32'd0);
        chk("rst_addr1", {24'b0, addr1}, 32'd0);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_busy", {31'b0, rd_busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) wb_xfer(vecs[i]);

        // Write with cyc dropped after the request edge: no ack, data lands
        cyc = 1; stb = 1; we = 1; adr = 32'h18; dat_i = 32'h12345678; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("drop_no_ack", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("drop_no_ack2", {31'b0, ack}, 32'd0);
        chk("dat_o_hold", dat_o, 32'h5A000008);
        v = '{1'b0, 32'h018, 32'h0, 4'hF, 8'h06, 4'h0, 32'h12345678};
        wb_xfer(v);

        // Reset asserted while the read is in CAPTURE
        cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = 4'hF; dat_i = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 0; stb = 0;
        #1;
        chk("rstc_ack", {31'b0, ack}, 32'd0);
        chk("rstc_csb0", {31'b0, csb0}, 32'd1);
        chk("rstc_dat_o", dat_o, 32'd0);
        chk("rstc_addr0", {24'b0, addr0}, 32'd0);
        @(posedge clk); #1;
        chk("rstc_ack2", {31'b0, ack}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        wb_xfer(vecs[1]);

`ifdef SRAM_CTRL_RDBURST_EN
        // Burst wrapping the top of the address space, ready high
        clear_mon();
        mon_en = 1'b1;
        rd_ready = 1'b1;
        burst_start(8'hFE, 9'd4);
        wait_words(4, 30);
        chk("b1_busy_clr", {31'b0, rd_busy}, 32'd0);
        if (busy_q.size() == 4)
            chk("b1_busy_last", {31'b0, busy_q[3]}, 32'd1);
        chk("b1_issues", iss_q.size(), 4);
        if (iss_q.size() == 4) begin
            chk("b1_a0", {24'b0, iss_q[0]}, 32'hFE);
            chk("b1_a1", {24'b0, iss_q[1]}, 32'hFF);
            chk("b1_a2", {24'b0, iss_q[2]}, 32'h00);
            chk("b1_a3", {24'b0, iss_q[3]}, 32'h01);
        end
        if (got_q.size() == 4) begin
            chk("b1_d0", got_q[0], 32'h5A0000FE);
            chk("b1_d1", got_q[1], 32'hA5A500FF);
            chk("b1_d2", got_q[2], 32'h5A0000CC);
            chk("b1_d3", got_q[3], 32'h5A000001);
            chk("b1_back2back", got_cyc[3] - got_cyc[0], 32'd3);
        end
        @(posedge clk); #1;
        chk("b1_valid_off", {31'b0, rd_valid}, 32'd0);

        // Backpressure: ready low for 6 cycles
        clear_mon();
        rd_ready = 1'b0;
        burst_start(8'h40, 9'd8);
        repeat (6) @(posedge clk);
        #1;
        chk("b2_issue_cap", iss_q.size(), 4);
        chk("b2_no_pop", got_q.size(), 0);
        chk("b2_valid", {31'b0, rd_valid}, 32'd1);
        rd_ready = 1'b1;
        wait_words(8, 40);
        chk("b2_busy_clr", {31'b0, rd_busy}, 32'd0);
        chk("b2_issues", iss_q.size(), 8);
        for (int i = 0; i < got_q.size(); i++)
            chk("b2_data", got_q[i], 32'h5A000040 + 32'(i));

        // Wishbone write lands while a burst is active
        clear_mon();
        coll_n = 0;
        burst_start(8'h80, 9'd8);
        v = '{1'b1, 32'h080, 32'h0BADF00D, 4'hF, 8'h20, 4'hF, 32'h0};
        wb_xfer(v);
        wait_words(8, 40);
        chk("b3_coll_seen", coll_n, 1);
        for (int i = 0; i < got_q.size(); i++)
            chk("b3_data", got_q[i], 32'h5A000080 + 32'(i));
        chk("b3_busy_clr", {31'b0, rd_busy}, 32'd0);
        mon_en = 1'b0;
        v = '{1'b0, 32'h080, 32'h0, 4'hF, 8'h20, 4'h0, 32'h0BADF00D};
        wb_xfer(v);
`else
        // Burst reader absent: start pulses have no effect
        clear_mon();
        mon_en = 1'b1;
        rd_ready = 1'b1;
        burst_start(8'h05, 9'd3);
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("nb_issues", iss_q.size(), 0);
        chk("nb_csb1", {31'b0, csb1}, 32'd1);
        chk("nb_addr1", {24'b0, addr1}, 32'd0);
        chk("nb_valid", {31'b0, rd_valid}, 32'd0);
        chk("nb_busy", {31'b0, rd_busy}, 32'd0);
        chk("nb_data", rd_data, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
